// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter wrapped around an 8-bit 2:1 mux. Two requesters (A, B)
// offer words with valid/ready. The granted word is captured in a one-entry
// output register that the downstream consumer drains with valid/ready.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   a_data     requester A word
//   a_valid    A offers a_data
//   a_ready    A's beat is accepted this cycle (combinational)
//   b_data     requester B word
//   b_valid    B offers b_data
//   b_ready    B's beat is accepted this cycle (combinational)
//   out_data   registered selected word
//   out_src    source of out_data (0 = A, 1 = B)
//   out_valid  out_data holds an unconsumed beat
//   out_ready  downstream accepts the beat
//   gnt_cnt_a  16-bit count of accepted A beats   (MUX2_ARB_GRANT_CNT_EN only)
//   gnt_cnt_b  16-bit count of accepted B beats   (MUX2_ARB_GRANT_CNT_EN only)
//
// Build option: define MUX2_ARB_GRANT_CNT_EN to add the per-requester grant
// counters. Without it the counter ports and logic are absent.

module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX2_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]      gnt_cnt_a,
    output logic [15:0]      gnt_cnt_b
`endif
);

    logic             prio;
    logic             load;
    logic             grant_valid;
    logic             grant;
    logic [WIDTH-1:0] mux_data;

    // Slot is free when empty, or when its current beat leaves this cycle.
    assign load = !out_valid || out_ready;

    // A lone requester always wins; prio only breaks ties.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (!reset && load) begin
            if (a_valid && b_valid) begin
                grant_valid = 1'b1;
                grant       = prio;
            end else if (a_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (b_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
        end
    end

    assign a_ready  = grant_valid && !grant;
    assign b_ready  = grant_valid && grant;
    assign mux_data = grant ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_src   <= 1'b0;
            out_valid <= 1'b0;
            prio      <= 1'b0;
        end else if (grant_valid) begin
            out_data  <= mux_data;
            out_src   <= grant;
            out_valid <= 1'b1;
            prio      <= !grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX2_ARB_GRANT_CNT_EN
    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt_a <= '0;
            gnt_cnt_b <= '0;
        end else begin
            if (a_ready) gnt_cnt_a <= gnt_cnt_a + 16'd1;
            if (b_ready) gnt_cnt_b <= gnt_cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;
`ifdef MUX2_ARB_GRANT_CNT_EN
    logic [15:0]      gnt_cnt_a;
    logic [15:0]      gnt_cnt_b;
`endif

    int checks;
    int errors;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX2_ARB_GRANT_CNT_EN
        ,
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'd2;
        b_data    = 8'd14;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 8'd0) begin
            errors++; $display("FAIL reset_out_data got %0d want 0", out_data);
        end
        checks++;
        if (out_src !== 1'b0) begin
            errors++; $display("FAIL reset_out_src got %b want 0", out_src);
        end
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_readies got %b want 00", {a_ready, b_ready});
        end
        reset   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
    endtask

    task automatic test_single_a();
        a_valid   = 1'b1;
        a_data    = 8'd2;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL single_a_ready got %b want 10", {a_ready, b_ready});
        end
        step();
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'd2}) begin
            errors++; $display("FAIL single_a_out got v=%b s=%b d=%0d want v=1 s=0 d=2", out_valid, out_src, out_data);
        end
        // prio is now 1: a tie must go to B.
        b_valid = 1'b1;
        b_data  = 8'd14;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL single_a_prio got %b want 01", {a_ready, b_ready});
        end
        step();
        checks++;
        if ({out_src, out_data} !== {1'b1, 8'd14}) begin
            errors++; $display("FAIL single_a_tie_out got s=%b d=%0d want s=1 d=14", out_src, out_data);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_data [4];
        logic       exp_src  [4];
        exp_data = '{8'd2, 8'd14, 8'd2, 8'd14};
        exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'd2;
        b_data    = 8'd14;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({out_valid, out_src, out_data} !== {1'b1, exp_src[i], exp_data[i]}) begin
                errors++;
                $display("FAIL alternate_%0d got v=%b s=%b d=%0d want v=1 s=%b d=%0d",
                         i, out_valid, out_src, out_data, exp_src[i], exp_data[i]);
            end
        end
    endtask

    // Follows test_alternate: B's 14 is held and prio favours A.
    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_ready, b_ready} !== 2'b00) begin
                errors++; $display("FAIL bp_readies_%0d got %b want 00", i, {a_ready, b_ready});
            end
            step();
            checks++;
            if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 8'd14}) begin
                errors++; $display("FAIL bp_hold_%0d got v=%b s=%b d=%0d want v=1 s=1 d=14", i, out_valid, out_src, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_release_ready got %b want 10", {a_ready, b_ready});
        end
        step();
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'd2}) begin
            errors++; $display("FAIL bp_no_bubble got v=%b s=%b d=%0d want v=1 s=0 d=2", out_valid, out_src, out_data);
        end
    endtask

    // Entered with prio=1 (A granted last).
    task automatic test_only_b();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'd1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({a_ready, b_ready} !== 2'b01) begin
                errors++; $display("FAIL only_b_ready_%0d got %b want 01", i, {a_ready, b_ready});
            end
            step();
            checks++;
            if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 8'd1}) begin
                errors++; $display("FAIL only_b_out_%0d got v=%b s=%b d=%0d want v=1 s=1 d=1", i, out_valid, out_src, out_data);
            end
        end
        // prio must be 0 now: a tie goes to A.
        a_valid = 1'b1;
        a_data  = 8'd2;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL only_b_prio_end got %b want 10", {a_ready, b_ready});
        end
        step();
    endtask

    // Entered with out_valid=1 and prio=1.
    task automatic test_reset_mid();
        out_ready = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        reset     = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL mid_reset_readies got %b want 00", {a_ready, b_ready});
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL mid_reset_out got v=%b d=%0d want v=0 d=0", out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL mid_reset_readies2 got %b want 00", {a_ready, b_ready});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_reset_first_grant got %b want 10", {a_ready, b_ready});
        end
        step();
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'd2}) begin
            errors++; $display("FAIL mid_reset_out2 got v=%b s=%b d=%0d want v=1 s=0 d=2", out_valid, out_src, out_data);
        end
    endtask

`ifdef MUX2_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        do_reset();
        checks++;
        if ({gnt_cnt_a, gnt_cnt_b} !== 32'd0) begin
            errors++; $display("FAIL cnt_reset got a=%0d b=%0d want 0 0", gnt_cnt_a, gnt_cnt_b);
        end
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        b_valid = 1'b0;
        step();
        checks++;
        if ({gnt_cnt_a, gnt_cnt_b} !== {16'd5, 16'd3}) begin
            errors++; $display("FAIL cnt_5_3 got a=%0d b=%0d want 5 3", gnt_cnt_a, gnt_cnt_b);
        end
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        checks++;
        if (gnt_cnt_a !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_full got %0d want 65535", gnt_cnt_a);
        end
        step();
        checks++;
        if (gnt_cnt_a !== 16'd0) begin
            errors++; $display("FAIL cnt_wrap got %0d want 0", gnt_cnt_a);
        end
        a_valid = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        a_data    = '0;
        b_data    = '0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_a();
        test_alternate();
        test_backpressure();
        test_only_b();
        test_reset_mid();
`ifdef MUX2_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
